sdram_refresh_sequencer: RTL
============================

Name: sdram_refresh_sequencer

Overview:
Executes SDRAM auto-refresh on the controller side of the refresh permission signal (doRefresh) produced by the loader-aware refresh arbiter. Tracks refreshes owed at the tREFI rate. When permission is high, requests the SDRAM command bus from the main controller. On grant, issues PRECHARGE-ALL followed by one or more AUTO REFRESH commands with tRP/tRFC spacing. Sits between the refresh arbiter and the SDRAM command mux.

Parameters:
- CLK_FREQ_HZ, 96_000_000: system clock frequency.
- TREFI_NS, 7800: refresh interval in ns. TREFI_CYCLES = (CLK_FREQ_HZ/1000)*TREFI_NS/1_000_000, truncated; 748 at defaults.
- TRP_CYCLES, 3: PRECHARGE-to-REFRESH spacing in clocks, min 1.
- TRFC_CYCLES, 7: REFRESH-to-next-command spacing in clocks, min 1.
- MAX_OWED, 8: owed-refresh saturation limit, 1..15.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: synchronous, active-high reset.
- refresh_en, in, 1: refresh permission level (arbiter doRefresh).
- ref_gnt, in, 1: command bus granted by main controller; banks idle.
- ref_req, out, 1: command bus request.
- ref_active, out, 1: high while the sequencer is driving cmd.
- cmd, out, 4: {CS_n, RAS_n, CAS_n, WE_n}.
- a10, out, 1: SDRAM A10; 1 during PRECHARGE-ALL.
- owed_count, out, 4: current owed refreshes.
- overflow, out, 1: sticky; owed count hit MAX_OWED while a tick was pending.

Behaviour:
- Reset values (applied on the first clk edge with reset=1, held while reset is high):
  - ref_req=0, ref_active=0, cmd=NOP (4'b0111), a10=0, owed_count=0, overflow=0.
  - Interval counter=0, FSM=IDLE.
- Reset mid-sequence aborts immediately to these values. No completion guarantee.
- Interval counter:
  - Free-runs 0..TREFI_CYCLES-1 regardless of refresh_en.
  - A tick occurs on wrap; the tick increments owed_count.
- owed_count arithmetic:
  - Saturates at MAX_OWED. A tick while at MAX_OWED sets overflow; overflow clears only on reset.
  - Decrements by 1 in the cycle a REF command is issued.
  - Tick and REF in the same cycle: owed_count unchanged. Overflow is not set, even at MAX_OWED.
- FSM states: IDLE, REQ, PRE, WAIT_RP, REF, WAIT_RFC.
  - IDLE: cmd=NOP. If refresh_en and owed_count>0, go to REQ and assert ref_req the next cycle.
  - REQ: ref_req=1.
    - If refresh_en drops before a grant, deassert ref_req and return to IDLE.
    - On ref_gnt=1, go to PRE.
  - PRE: one cycle. cmd=PRECHARGE (4'b0010), a10=1, ref_active=1.
  - WAIT_RP: cmd=NOP for TRP_CYCLES-1 cycles, then REF. If TRP_CYCLES=1, skip directly to REF.
  - REF: one cycle. cmd=AUTO REFRESH (4'b0001), a10=0, owed_count decrements.
  - WAIT_RFC: cmd=NOP for TRFC_CYCLES-1 cycles. On the last cycle:
    - Burst: if refresh_en=1 and owed_count>0, go to REF again. No re-precharge; banks are still closed.
    - Otherwise go to IDLE. ref_req and ref_active deassert on entry to IDLE.
- ref_gnt is sampled only in REQ. Deassertion after PRE is ignored; the controller must not revoke the grant.
- refresh_en dropping after PRE only ends the burst at the next WAIT_RFC exit. The in-flight REF always completes.
- ref_active=1 from PRE through WAIT_RFC inclusive.
- ref_req=1 from REQ through WAIT_RFC inclusive.
- Latency: ref_gnt high in REQ → PRE cmd on the next clk → first REF exactly TRP_CYCLES clocks after PRE.
- Minimum REF-to-REF spacing within a burst: TRFC_CYCLES clocks.

Decomposition:
- Package sdram_cmd_pkg:
  - 4-bit command constants: CMD_NOP 4'b0111, CMD_PRE 4'b0010, CMD_REF 4'b0001, CMD_ACT 4'b0011, CMD_RD 4'b0101, CMD_WR 4'b0100.
  - FSM state enum typedef.
  - Function computing TREFI_CYCLES from parameters.
- Sub-module refresh_interval_timer: free-running interval counter plus the saturating owed counter and overflow flag. The sequencer FSM instantiates it and feeds it a dec pulse.

Test Plan:
1. Reset, refresh_en=1, ref_gnt tied 1. Expected:
   - Tick at cycle 748 after reset release → ref_req high next cycle → PRE.
   - REF 3 clocks after PRE; owed 1→0.
   - IDLE after 7 clocks of RFC.
2. refresh_en=0 for 3×748 cycles, then 1 with ref_gnt=1. Expected:
   - owed_count=3 before enable.
   - One PRE, then three REFs spaced 7 clocks apart, owed 3→0.
   - ref_req drops after the final WAIT_RFC.
3. refresh_en=0 for 10×748 cycles. Expected:
   - owed_count saturates at 8; overflow=1 after the 9th tick.
   - overflow stays 1 after the refreshes drain.
4. ref_req asserted with ref_gnt held 0 for 50 cycles, then 1. Expected:
   - cmd stays NOP throughout the wait; PRE on the clock after the grant.
   - refresh_en dropping during the wait instead returns to IDLE with ref_req=0.
5. Force a tick on the same cycle as a REF with owed_count=2. Expected: owed_count stays 2, overflow stays 0.
6. Assert reset during WAIT_RFC of a burst. Expected:
   - Next clk: cmd=NOP, ref_req=0, ref_active=0, owed_count=0, overflow=0.
   - No further commands until a new tick.

Source files
------------

// File: rtl/sdram_cmd_pkg.sv
// Shared SDRAM command encodings, refresh sequencer state type and tREFI helper.
package sdram_cmd_pkg;

  // {CS_n, RAS_n, CAS_n, WE_n}
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_PRE,
    ST_WAIT_RP,
    ST_REF,
    ST_WAIT_RFC
  } ref_state_t;

  // Truncating conversion of the refresh interval into clock cycles.
  function automatic int unsigned trefi_cycles(input int unsigned clk_hz,
                                               input int unsigned trefi_ns);
    longint unsigned cyc;
    cyc = (longint'(clk_hz) / 64'd1000) * longint'(trefi_ns) / 64'd1_000_000;
    return 32'(cyc);
  endfunction

endpackage

// File: rtl/refresh_interval_timer.sv
// Free-running tREFI interval counter feeding a saturating owed-refresh count
// with a sticky overflow flag.
module refresh_interval_timer #(
  parameter int unsigned TREFI_CYCLES = 748,
  parameter int unsigned MAX_OWED     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dec,
  output logic       tick,
  output logic [3:0] owed_count,
  output logic       overflow
);

  localparam int unsigned CNT_W = (TREFI_CYCLES > 1) ? $clog2(TREFI_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TREFI_CYCLES - 1);
  localparam logic [3:0] OWED_MAX = 4'(MAX_OWED);

  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_owed;
  logic             r_overflow;
  logic             w_tick;

  assign w_tick = (r_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // A tick and a refresh in the same cycle cancel, so overflow cannot be set then.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_owed     <= '0;
      r_overflow <= 1'b0;
    end else begin
      case ({w_tick, dec})
        2'b10: begin
          if (r_owed == OWED_MAX) r_overflow <= 1'b1;
          else                    r_owed     <= r_owed + 4'd1;
        end
        2'b01: begin
          if (r_owed != 4'd0) r_owed <= r_owed - 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign tick       = w_tick;
  assign owed_count = r_owed;
  assign overflow   = r_overflow;

endmodule

// File: rtl/sdram_refresh_sequencer.sv
// Controller-side SDRAM auto-refresh executor: requests the command bus when
// refresh is permitted and owed, then issues PRECHARGE-ALL and a REF burst.
module sdram_refresh_sequencer
  import sdram_cmd_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 96_000_000,
  parameter int unsigned TREFI_NS    = 7800,
  parameter int unsigned TRP_CYCLES  = 3,
  parameter int unsigned TRFC_CYCLES = 7,
  parameter int unsigned MAX_OWED    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       refresh_en,
  input  logic       ref_gnt,
  output logic       ref_req,
  output logic       ref_active,
  output logic [3:0] cmd,
  output logic       a10,
  output logic [3:0] owed_count,
  output logic       overflow
);

  localparam int unsigned TREFI_CYCLES = trefi_cycles(CLK_FREQ_HZ, TREFI_NS);
  localparam int unsigned WAIT_MAX = (TRP_CYCLES > TRFC_CYCLES) ? TRP_CYCLES : TRFC_CYCLES;
  localparam int unsigned WAIT_W   = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;
  // Wait states count down to zero, so they are entered with (cycles-1)-1.
  localparam logic [WAIT_W-1:0] RP_LOAD  = WAIT_W'((TRP_CYCLES  > 1) ? TRP_CYCLES  - 2 : 0);
  localparam logic [WAIT_W-1:0] RFC_LOAD = WAIT_W'((TRFC_CYCLES > 1) ? TRFC_CYCLES - 2 : 0);

  ref_state_t        r_state;
  ref_state_t        w_state_nxt;
  logic [WAIT_W-1:0] r_wait;
  logic [WAIT_W-1:0] w_wait_nxt;
  logic              r_ref_req;
  logic              r_ref_active;
  logic [3:0]        r_cmd;
  logic              r_a10;
  logic              w_dec;
  logic              w_tick;
  logic [3:0]        w_owed;
  logic              w_overflow;

  assign w_dec = (r_state == ST_REF);

  refresh_interval_timer #(
    .TREFI_CYCLES (TREFI_CYCLES),
    .MAX_OWED     (MAX_OWED)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .dec        (w_dec),
    .tick       (w_tick),
    .owed_count (w_owed),
    .overflow   (w_overflow)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait;
    case (r_state)
      ST_IDLE: begin
        if (refresh_en && (w_owed != 4'd0)) w_state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (!refresh_en)  w_state_nxt = ST_IDLE;
        else if (ref_gnt) w_state_nxt = ST_PRE;
      end
      ST_PRE: begin
        if (TRP_CYCLES <= 1) begin
          w_state_nxt = ST_REF;
        end else begin
          w_state_nxt = ST_WAIT_RP;
          w_wait_nxt  = RP_LOAD;
        end
      end
      ST_WAIT_RP: begin
        if (r_wait == '0) w_state_nxt = ST_REF;
        else              w_wait_nxt  = r_wait - WAIT_W'(1);
      end
      ST_REF: begin
        // With no RFC wait the decision is taken before this REF's decrement lands.
        if (TRFC_CYCLES <= 1) begin
          w_state_nxt = (refresh_en && ((w_owed > 4'd1) || w_tick)) ? ST_REF : ST_IDLE;
        end else begin
          w_state_nxt = ST_WAIT_RFC;
          w_wait_nxt  = RFC_LOAD;
        end
      end
      ST_WAIT_RFC: begin
        if (r_wait == '0) w_state_nxt = (refresh_en && (w_owed != 4'd0)) ? ST_REF : ST_IDLE;
        else              w_wait_nxt  = r_wait - WAIT_W'(1);
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so cmd lines up with r_state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_wait       <= '0;
      r_ref_req    <= 1'b0;
      r_ref_active <= 1'b0;
      r_cmd        <= CMD_NOP;
      r_a10        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_wait       <= w_wait_nxt;
      r_ref_req    <= (w_state_nxt != ST_IDLE);
      r_ref_active <= (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_REQ);
      r_cmd        <= (w_state_nxt == ST_PRE) ? CMD_PRE :
                      (w_state_nxt == ST_REF) ? CMD_REF : CMD_NOP;
      r_a10        <= (w_state_nxt == ST_PRE);
    end
  end

  assign ref_req    = r_ref_req;
  assign ref_active = r_ref_active;
  assign cmd        = r_cmd;
  assign a10        = r_a10;
  assign owed_count = w_owed;
  assign overflow   = w_overflow;

endmodule
